// File: rtl/sdram_pkg.sv
// sdram_pkg: SDRAM address geometry, data width, arbiter FSM states and address helpers
package sdram_pkg;
  localparam int RowWidth = 12;
  localparam int ColWidth = 8;
  localparam int BankWidth = 2;
  localparam int AddrWidth = RowWidth + ColWidth + BankWidth;
  localparam int DataWidth = 16;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_e;
  typedef struct packed {
    logic [RowWidth-1:0] row;
    logic [ColWidth-1:0] col;
    logic [BankWidth-1:0] bank;
  } addr_t;
  function automatic logic [AddrWidth-1:0] pack_addr(input logic [RowWidth-1:0] row,
                                                     input logic [ColWidth-1:0] col,
                                                     input logic [BankWidth-1:0] bank);
    return {row, col, bank};
  endfunction
  function automatic addr_t unpack_addr(input logic [AddrWidth-1:0] a);
    return addr_t'(a);
  endfunction
endpackage

// File: rtl/sdram_port_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first request at or after i_ptr
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  input  logic         i_en,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx
);
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      int j;
      j = (int'(i_ptr) + i) % N;
      if (i_en && i_req[j]) begin
        o_gnt = '0;
        o_gnt[j] = 1'b1;
        o_idx = W'(j);
      end
    end
  end
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin sequencer sharing the sdram_ctrl request port among clients
module sdram_port_arbiter
  import sdram_pkg::*;
#(
  parameter int NumPorts = 4,
  parameter int AddrWidth = 22,
  parameter int DataWidth = 16,
  parameter int TimeoutCycles = 1024
) (
  input  logic                          i_sys_clk,
  input  logic                          i_rst_n,
  input  logic [NumPorts-1:0]           i_req,
  input  logic [NumPorts-1:0]           i_we,
  input  logic [NumPorts*AddrWidth-1:0] i_addr,
  input  logic [NumPorts*DataWidth-1:0] i_wdata,
  output logic [NumPorts-1:0]           o_gnt,
  output logic [NumPorts-1:0]           o_rd_valid,
  output logic [DataWidth-1:0]          o_rd_data,
  output logic                          o_busy,
  output logic                          o_timeout,
  output logic                          o_wr_req,
  output logic                          o_rd_req,
  output logic [AddrWidth-1:0]          o_ctrl_addr,
  output logic [DataWidth-1:0]          o_ctrl_wdata,
  input  logic                          i_ctrl_ready,
  input  logic                          i_ctrl_done,
  input  logic [DataWidth-1:0]          i_rd_data
);
  localparam int PW = $clog2(NumPorts);
  localparam int CW = $clog2(TimeoutCycles);
  arb_state_e r_state, w_next;
  logic [PW-1:0] r_ptr, r_idx, w_idx;
  logic [NumPorts-1:0] w_win, w_onehot, r_rd_valid;
  logic [AddrWidth-1:0] r_addr;
  logic [DataWidth-1:0] r_wdata, r_rd_data;
  logic [CW-1:0] r_cnt;
  logic r_we, r_timeout, w_arb, w_done, w_to;
  rr_arbiter #(.N(NumPorts)) u_rr (
    .i_req(i_req),
    .i_ptr(r_ptr),
    .i_en(r_state == IDLE && i_ctrl_ready),
    .o_gnt(w_win),
    .o_idx(w_idx)
  );
  assign w_arb = |w_win;
  assign w_done = r_state == WAIT && i_ctrl_done;
  assign w_to = r_state == WAIT && !i_ctrl_done && r_cnt == CW'(TimeoutCycles - 1);
  assign w_onehot = NumPorts'(1) << r_idx;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_arb ? ISSUE : IDLE;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = (w_done || w_to) ? IDLE : WAIT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_sys_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge i_sys_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_ptr <= '0;
      r_idx <= '0;
      r_we <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_cnt <= '0;
      r_rd_valid <= '0;
      r_rd_data <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_arb) begin
        r_idx <= w_idx;
        r_we <= i_we[w_idx];
        r_addr <= i_addr[w_idx*AddrWidth +: AddrWidth];
        r_wdata <= i_wdata[w_idx*DataWidth +: DataWidth];
      end
      if (r_state == ISSUE) r_ptr <= r_idx == PW'(NumPorts - 1) ? '0 : r_idx + 1'b1;
      r_cnt <= (r_state == WAIT && !w_done && !w_to) ? r_cnt + 1'b1 : '0;
      r_rd_valid <= (w_done && !r_we) ? w_onehot : '0;
      if (w_done && !r_we) r_rd_data <= i_rd_data;
      r_timeout <= r_timeout | w_to;
    end
  assign o_gnt = r_state == ISSUE ? w_onehot : '0;
  assign o_wr_req = r_state == ISSUE && r_we;
  assign o_rd_req = r_state == ISSUE && !r_we;
  assign o_ctrl_addr = r_addr;
  assign o_ctrl_wdata = r_wdata;
  assign o_rd_valid = r_rd_valid;
  assign o_rd_data = r_rd_data;
  assign o_busy = r_state != IDLE;
  assign o_timeout = r_timeout;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: scenario tasks with a read-data scoreboard for sdram_port_arbiter
module tb_sdram_port_arbiter;
  import sdram_pkg::*;
  localparam int NP = 4;
  localparam int AW = 22;
  localparam int DW = 16;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst_n;
  logic [NP-1:0] i_req, i_we, o_gnt, o_rd_valid;
  logic [NP*AW-1:0] i_addr;
  logic [NP*DW-1:0] i_wdata;
  logic [DW-1:0] o_rd_data, o_ctrl_wdata, i_rd_data;
  logic [AW-1:0] o_ctrl_addr;
  logic o_busy, o_timeout, o_wr_req, o_rd_req, i_ctrl_ready, i_ctrl_done;
  int n_checks = 0;
  int n_fail = 0;
  logic [NP+DW-1:0] sb[$];

  sdram_port_arbiter #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)) dut (
    .i_sys_clk(clk), .i_rst_n(rst_n), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_gnt(o_gnt), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
    .o_busy(o_busy), .o_timeout(o_timeout), .o_wr_req(o_wr_req), .o_rd_req(o_rd_req),
    .o_ctrl_addr(o_ctrl_addr), .o_ctrl_wdata(o_ctrl_wdata), .i_ctrl_ready(i_ctrl_ready),
    .i_ctrl_done(i_ctrl_done), .i_rd_data(i_rd_data)
  );

  always #5 clk = ~clk;

  // every read-data pulse must match the oldest expected (port, data) pair
  always @(negedge clk)
    if (o_rd_valid != '0) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rd_valid_sb: unexpected rd_valid=%b data=%h", o_rd_valid, o_rd_data);
      end else begin
        logic [NP+DW-1:0] e;
        e = sb.pop_front();
        if ({o_rd_valid, o_rd_data} !== e) begin
          n_fail++;
          $display("FAIL rd_valid_sb: got %b/%h want %b/%h", o_rd_valid, o_rd_data, e[NP+DW-1:DW], e[DW-1:0]);
        end
      end
    end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    i_we[k] = we;
    i_addr[k*AW +: AW] = a;
    i_wdata[k*DW +: DW] = d;
  endtask

  task automatic wait_gnt(input int max_cycles, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (o_gnt == '0 && n < max_cycles);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({o_gnt, o_rd_valid, o_rd_data, o_busy, o_timeout, o_wr_req, o_rd_req, o_ctrl_addr, o_ctrl_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_held: outputs not all zero (gnt=%b busy=%b addr=%h)", o_gnt, o_busy, o_ctrl_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({o_gnt, o_rd_valid, o_busy, o_timeout, o_wr_req, o_rd_req} !== '0) begin
      n_fail++;
      $display("FAIL reset_release: gnt=%b rdv=%b busy=%b to=%b want all 0", o_gnt, o_rd_valid, o_busy, o_timeout);
    end
  endtask

  task automatic test_single_write();
    int n;
    logic [AW-1:0] a;
    a = pack_addr(12'd13, 8'd5, 2'd0);
    set_port(2, 1'b1, a, 16'hBEEF);
    i_req = 4'b0100;
    wait_gnt(8, n);
    n_checks++;
    if (n !== 1 || o_gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL wr_gnt: got %b after %0d cycles want 0100 after 1", o_gnt, n);
    end
    n_checks++;
    if ({o_wr_req, o_rd_req} !== 2'b10) begin
      n_fail++;
      $display("FAIL wr_req: got wr=%b rd=%b want wr=1 rd=0", o_wr_req, o_rd_req);
    end
    n_checks++;
    if (o_ctrl_addr !== a || o_ctrl_wdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL wr_payload: got %h/%h want %h/beef", o_ctrl_addr, o_ctrl_wdata, a);
    end
    i_req = '0;
    tick();
    n_checks++;
    if (o_busy !== 1'b1 || o_gnt !== '0 || o_wr_req !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_wait: busy=%b gnt=%b wr=%b want 1/0000/0", o_busy, o_gnt, o_wr_req);
    end
    i_ctrl_done = 1'b1;
    tick();
    i_ctrl_done = 1'b0;
    n_checks++;
    if (o_busy !== 1'b0 || o_rd_valid !== '0) begin
      n_fail++;
      $display("FAIL wr_done: busy=%b rdv=%b want 0/0000", o_busy, o_rd_valid);
    end
    tick();
    n_checks++;
    if (o_rd_valid !== '0 || o_ctrl_addr !== a) begin
      n_fail++;
      $display("FAIL wr_after: rdv=%b addr=%h want 0000/%h", o_rd_valid, o_ctrl_addr, a);
    end
  endtask

  task automatic test_single_read();
    int n;
    logic [AW-1:0] a;
    a = pack_addr(12'd7, 8'd3, 2'd1);
    set_port(1, 1'b0, a, 16'h0000);
    i_req = 4'b0010;
    wait_gnt(8, n);
    n_checks++;
    if (n !== 1 || o_gnt !== 4'b0010 || {o_wr_req, o_rd_req} !== 2'b01 || o_ctrl_addr !== a) begin
      n_fail++;
      $display("FAIL rd_issue: gnt=%b n=%0d wr/rd=%b%b addr=%h want 0010 1 01 %h", o_gnt, n, o_wr_req, o_rd_req, o_ctrl_addr, a);
    end
    i_req = '0;
    repeat (7) tick();
    i_rd_data = 16'h1234;
    i_ctrl_done = 1'b1;
    sb.push_back({4'b0010, 16'h1234});
    tick();
    i_ctrl_done = 1'b0;
    i_rd_data = 16'hDEAD;
    n_checks++;
    if (o_rd_valid !== 4'b0010 || o_rd_data !== 16'h1234 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_data: rdv=%b data=%h busy=%b want 0010/1234/0", o_rd_valid, o_rd_data, o_busy);
    end
    tick();
    n_checks++;
    if (o_rd_valid !== '0 || o_rd_data !== 16'h1234) begin
      n_fail++;
      $display("FAIL rd_pulse: rdv=%b data=%h want 0000/1234", o_rd_valid, o_rd_data);
    end
  endtask

  task automatic test_fairness();
    int n;
    int exp_port[$];
    do_reset();
    exp_port = '{0, 1, 2, 3, 0, 1};
    for (int k = 0; k < NP; k++) set_port(k, 1'b0, pack_addr(12'(k), 8'(k), 2'(k)), 16'h0);
    i_req = '1;
    for (int i = 0; i < 6; i++) begin
      int p;
      logic [NP-1:0] e;
      p = exp_port.pop_front();
      e = NP'(1) << p;
      wait_gnt(8, n);
      n_checks++;
      if (o_gnt !== e || o_rd_req !== 1'b1) begin
        n_fail++;
        $display("FAIL fair_gnt%0d: got %b rd=%b want %b rd=1", i, o_gnt, o_rd_req, e);
      end
      repeat (3) tick();
      i_rd_data = 16'hA000 + 16'(i);
      i_ctrl_done = 1'b1;
      sb.push_back({e, 16'hA000 + 16'(i)});
      tick();
      i_ctrl_done = 1'b0;
    end
    i_req = '0;
    tick();
  endtask

  task automatic test_not_ready();
    logic bad;
    bad = 1'b0;
    i_ctrl_ready = 1'b0;
    set_port(0, 1'b1, pack_addr(12'd100, 8'd200, 2'd3), 16'h5A5A);
    i_req = 4'b0001;
    repeat (100) begin
      tick();
      bad |= (|o_gnt) | o_wr_req | o_rd_req | o_busy;
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL not_ready: activity seen=%b want 0", bad);
    end
    i_ctrl_ready = 1'b1;
    tick();
    n_checks++;
    if (o_gnt !== 4'b0001 || o_wr_req !== 1'b1 || o_ctrl_wdata !== 16'h5A5A) begin
      n_fail++;
      $display("FAIL ready_gnt: gnt=%b wr=%b wdata=%h want 0001/1/5a5a", o_gnt, o_wr_req, o_ctrl_wdata);
    end
    i_req = '0;
    tick();
    i_ctrl_done = 1'b1;
    tick();
    i_ctrl_done = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    logic bad;
    n_checks++;
    if (o_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL to_pre: timeout=%b want 0", o_timeout);
    end
    set_port(3, 1'b0, pack_addr(12'd1, 8'd2, 2'd3), 16'h0);
    i_req = 4'b1000;
    wait_gnt(8, n);
    n_checks++;
    if (o_gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL to_gnt: got %b want 1000", o_gnt);
    end
    i_req = '0;
    n = 0;
    bad = 1'b0;
    do begin
      tick();
      n++;
      bad |= |o_rd_valid;
    end while (o_busy && n < 40);
    n_checks++;
    if (n !== TO + 1 || o_timeout !== 1'b1 || bad !== 1'b0) begin
      n_fail++;
      $display("FAIL to_fire: idle after %0d cycles timeout=%b rdv_seen=%b want %0d/1/0", n, o_timeout, bad, TO + 1);
    end
    set_port(0, 1'b1, pack_addr(12'd9, 8'd9, 2'd1), 16'hC0DE);
    i_req = 4'b0001;
    wait_gnt(8, n);
    n_checks++;
    if (o_gnt !== 4'b0001 || o_wr_req !== 1'b1) begin
      n_fail++;
      $display("FAIL to_next: gnt=%b wr=%b want 0001/1", o_gnt, o_wr_req);
    end
    i_req = '0;
    tick();
    i_ctrl_done = 1'b1;
    tick();
    i_ctrl_done = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (o_timeout !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL to_sticky: timeout=%b busy=%b want 1/0", o_timeout, o_busy);
    end
  endtask

  task automatic test_reset_in_wait();
    int n;
    logic bad;
    set_port(1, 1'b0, pack_addr(12'd77, 8'd1, 2'd2), 16'h0);
    i_req = 4'b0010;
    wait_gnt(8, n);
    i_req = '0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_gnt, o_rd_valid, o_rd_data, o_busy, o_timeout, o_wr_req, o_rd_req, o_ctrl_addr, o_ctrl_wdata} !== '0) begin
      n_fail++;
      $display("FAIL async_rst: busy=%b to=%b data=%h addr=%h want all 0", o_busy, o_timeout, o_rd_data, o_ctrl_addr);
    end
    #3;
    rst_n = 1'b1;
    tick();
    i_rd_data = 16'hFFFF;
    i_ctrl_done = 1'b1;
    bad = 1'b0;
    tick();
    i_ctrl_done = 1'b0;
    repeat (3) begin
      bad |= (|o_rd_valid) | o_busy | (|o_gnt);
      tick();
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL late_done: activity after reset=%b want 0", bad);
    end
    set_port(0, 1'b0, pack_addr(12'd5, 8'd6, 2'd0), 16'h0);
    i_req = 4'b0011;
    wait_gnt(8, n);
    n_checks++;
    if (o_gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL ptr_restart: got %b want 0001", o_gnt);
    end
    i_req = '0;
    tick();
    i_rd_data = 16'h0BAD;
    i_ctrl_done = 1'b1;
    sb.push_back({4'b0001, 16'h0BAD});
    tick();
    i_ctrl_done = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    i_req = '0;
    i_we = '0;
    i_addr = '0;
    i_wdata = '0;
    i_ctrl_ready = 1'b1;
    i_ctrl_done = 1'b0;
    i_rd_data = '0;
    test_reset();
    test_single_write();
    test_single_read();
    test_fairness();
    test_not_ready();
    test_timeout();
    test_reset_in_wait();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expected reads never seen, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
